// File: rtl/ibex_pkg.sv
// Shared types and constants for the multiplier-array arbiter.
package ibex_pkg;

  localparam int unsigned MulLanes = 4;
  localparam int unsigned MulOpW   = 17;
  localparam int unsigned MulProdW = 34;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_MD_LOCK = 2'd1,
    ARB_NU_LOCK = 2'd2
  } mul_arb_state_e;

  typedef enum logic {
    OWN_MD = 1'b0,
    OWN_NU = 1'b1
  } mul_owner_e;

endpackage

// File: rtl/ibex_mult_arbiter_if.sv
// Requester, array and status signals of the multiplier arbiter; slave = arbiter side.
interface ibex_mult_arbiter_if
  import ibex_pkg::*;
#(
  parameter int unsigned NumLanes = MulLanes,
  parameter int unsigned OpW      = MulOpW,
  parameter int unsigned ProdW    = MulProdW
) ();

  logic             md_req_i;
  logic             md_lock_i;
  logic             md_normal_i;
  logic [OpW-1:0]   md_w_i [NumLanes];
  logic [OpW-1:0]   md_a_i [NumLanes];
  logic             md_gnt_o;
  logic             md_rvalid_o;
  logic [ProdW-1:0] md_p_o [NumLanes];

  logic             nu_req_i;
  logic             nu_lock_i;
  logic [OpW-1:0]   nu_w_i [NumLanes];
  logic [OpW-1:0]   nu_a_i [NumLanes];
  logic             nu_gnt_o;
  logic             nu_rvalid_o;
  logic [31:0]      nu_p_o [NumLanes];

  logic [OpW-1:0]   mul_w_o [NumLanes];
  logic [OpW-1:0]   mul_a_o [NumLanes];
  logic             mul_normal_o;
  logic [ProdW-1:0] mul_p_i [NumLanes];

  logic             busy_o;

  modport slave (
    input  md_req_i, md_lock_i, md_normal_i, md_w_i, md_a_i,
    input  nu_req_i, nu_lock_i, nu_w_i, nu_a_i, mul_p_i,
    output md_gnt_o, md_rvalid_o, md_p_o,
    output nu_gnt_o, nu_rvalid_o, nu_p_o,
    output mul_w_o, mul_a_o, mul_normal_o, busy_o
  );

  modport master (
    output md_req_i, md_lock_i, md_normal_i, md_w_i, md_a_i,
    output nu_req_i, nu_lock_i, nu_w_i, nu_a_i, mul_p_i,
    input  md_gnt_o, md_rvalid_o, md_p_o,
    input  nu_gnt_o, nu_rvalid_o, nu_p_o,
    input  mul_w_o, mul_a_o, mul_normal_o, busy_o
  );

endinterface

// File: rtl/ibex_mult_arb_pick.sv
// Combinational grant selection and next-state logic for the multiplier arbiter.
module ibex_mult_arb_pick
  import ibex_pkg::*;
(
  input  mul_arb_state_e state_i,
  input  logic           md_req_i,
  input  logic           md_lock_i,
  input  logic           nu_req_i,
  input  logic           nu_lock_i,
  input  logic           nu_force_i,
  output logic           md_gnt_o,
  output logic           nu_gnt_o,
  output mul_arb_state_e state_o
);

  // Priority grant in idle; a lock holder is never preempted.
  always_comb begin
    md_gnt_o = 1'b0;
    nu_gnt_o = 1'b0;
    state_o  = state_i;
    case (state_i)
      ARB_IDLE: begin
        if (nu_req_i && nu_force_i) begin
          nu_gnt_o = 1'b1;
          state_o  = nu_lock_i ? ARB_NU_LOCK : ARB_IDLE;
        end else if (md_req_i) begin
          md_gnt_o = 1'b1;
          state_o  = md_lock_i ? ARB_MD_LOCK : ARB_IDLE;
        end else if (nu_req_i) begin
          nu_gnt_o = 1'b1;
          state_o  = nu_lock_i ? ARB_NU_LOCK : ARB_IDLE;
        end else begin
          state_o  = ARB_IDLE;
        end
      end
      ARB_MD_LOCK: begin
        if (md_req_i) begin
          md_gnt_o = 1'b1;
          state_o  = md_lock_i ? ARB_MD_LOCK : ARB_IDLE;
        end else begin
          state_o  = ARB_IDLE;
        end
      end
      ARB_NU_LOCK: begin
        if (nu_req_i) begin
          nu_gnt_o = 1'b1;
          state_o  = nu_lock_i ? ARB_NU_LOCK : ARB_IDLE;
        end else begin
          state_o  = ARB_IDLE;
        end
      end
      default: begin
        state_o  = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ibex_mult_arbiter.sv
// Arbiter/sequencer for the shared four-lane multiplier array.
// Optional neural starvation guard: define IBEX_MULT_ARB_STARVE_GUARD_EN.
module ibex_mult_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned NumLanes = MulLanes,
  parameter int unsigned OpW      = MulOpW,
  parameter int unsigned ProdW    = MulProdW,
  parameter int unsigned MaxWait  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_mult_arbiter_if.slave  bus_if
);

  mul_arb_state_e state_q, state_d;
  logic           md_gnt_s, nu_gnt_s, nu_force_s;
  logic           valid_q, valid_d;
  mul_owner_e     owner_q, owner_d;
  logic           normal_q, normal_d;
  logic [OpW-1:0] w_q [NumLanes];
  logic [OpW-1:0] w_d [NumLanes];
  logic [OpW-1:0] a_q [NumLanes];
  logic [OpW-1:0] a_d [NumLanes];
  logic             md_rvalid_s, nu_rvalid_s;
  logic [ProdW-1:0] md_p_s [NumLanes];
  logic [31:0]      nu_p_s [NumLanes];

  ibex_mult_arb_pick u_pick (
    .state_i    (state_q),
    .md_req_i   (bus_if.md_req_i),
    .md_lock_i  (bus_if.md_lock_i),
    .nu_req_i   (bus_if.nu_req_i),
    .nu_lock_i  (bus_if.nu_lock_i),
    .nu_force_i (nu_force_s),
    .md_gnt_o   (md_gnt_s),
    .nu_gnt_o   (nu_gnt_s),
    .state_o    (state_d)
  );

`ifdef IBEX_MULT_ARB_STARVE_GUARD_EN
  localparam int unsigned WaitW = $clog2(MaxWait + 1);
  logic [WaitW-1:0] wait_q, wait_d;

  // Neural wait counter: saturates at MaxWait, clears on any neural grant.
  always_comb begin
    wait_d = wait_q;
    if (nu_gnt_s) begin
      wait_d = {WaitW{1'b0}};
    end else if (bus_if.nu_req_i && (wait_q != WaitW'(MaxWait))) begin
      wait_d = wait_q + {{(WaitW-1){1'b0}}, 1'b1};
    end else begin
      wait_d = wait_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= {WaitW{1'b0}};
    end else begin
      wait_q <= wait_d;
    end
  end

  assign nu_force_s = (wait_q == WaitW'(MaxWait));
`else
  logic unused_max_wait;
  assign unused_max_wait = (MaxWait >= 32'd1);
  assign nu_force_s      = 1'b0;
`endif

  // Next operand/tag values; ungranted cycles hold the array inputs to avoid toggling.
  always_comb begin
    valid_d  = md_gnt_s | nu_gnt_s;
    owner_d  = owner_q;
    normal_d = normal_q;
    w_d      = w_q;
    a_d      = a_q;
    if (md_gnt_s) begin
      owner_d  = OWN_MD;
      normal_d = bus_if.md_normal_i;
      w_d      = bus_if.md_w_i;
      a_d      = bus_if.md_a_i;
    end else if (nu_gnt_s) begin
      owner_d  = OWN_NU;
      normal_d = 1'b0;
      w_d      = bus_if.nu_w_i;
      a_d      = bus_if.nu_a_i;
    end else begin
      owner_d  = owner_q;
    end
  end

  // Arbiter state, owner tag and registered array operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      valid_q  <= 1'b0;
      owner_q  <= OWN_MD;
      normal_q <= 1'b0;
      for (int l = 0; l < NumLanes; l++) begin
        w_q[l] <= {OpW{1'b0}};
        a_q[l] <= {OpW{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      normal_q <= normal_d;
      w_q      <= w_d;
      a_q      <= a_d;
    end
  end

  assign md_rvalid_s = valid_q && (owner_q == OWN_MD);
  assign nu_rvalid_s = valid_q && (owner_q == OWN_NU);

  // Route array products only to the tagged owner; the other side reads zero.
  always_comb begin
    for (int l = 0; l < NumLanes; l++) begin
      md_p_s[l] = md_rvalid_s ? bus_if.mul_p_i[l] : {ProdW{1'b0}};
      nu_p_s[l] = nu_rvalid_s ? bus_if.mul_p_i[l][31:0] : 32'h0000_0000;
    end
  end

  assign bus_if.md_gnt_o     = md_gnt_s;
  assign bus_if.nu_gnt_o     = nu_gnt_s;
  assign bus_if.md_rvalid_o  = md_rvalid_s;
  assign bus_if.nu_rvalid_o  = nu_rvalid_s;
  assign bus_if.md_p_o       = md_p_s;
  assign bus_if.nu_p_o       = nu_p_s;
  assign bus_if.mul_w_o      = w_q;
  assign bus_if.mul_a_o      = a_q;
  assign bus_if.mul_normal_o = normal_q;
  assign bus_if.busy_o       = (state_q != ARB_IDLE) || valid_q;

endmodule

// File: tb/tb_ibex_mult_arbiter.sv
// Self-checking bench for ibex_mult_arbiter: directed scenarios plus random traffic vs. a reference model.
module tb_ibex_mult_arbiter;

  localparam int L    = 4;
  localparam int OW   = 17;
  localparam int PW   = 34;
  localparam int MAXW = 3;
`ifdef IBEX_MULT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_mult_arbiter_if #(.NumLanes(L), .OpW(OW), .ProdW(PW)) bus ();

  ibex_mult_arbiter #(.NumLanes(L), .OpW(OW), .ProdW(PW), .MaxWait(MAXW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: lock holder (0 none, 1 md, 2 nu), wait count, last accepted beat.
  int                     m_lock, m_wait, m_owner;
  bit                     m_valid, m_normal;
  logic signed [OW-1:0]   m_w [L];
  logic signed [OW-1:0]   m_a [L];

  logic          seen_md_gnt, seen_nu_gnt, seen_md_rvalid;
  logic [PW-1:0] seen_md_p0;
  logic [31:0]   seen_nu_p0;
  logic [OW-1:0] seen_mul_w0;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_wait = 0; m_owner = 1; m_valid = 1'b0; m_normal = 1'b0;
    for (int l = 0; l < L; l++) begin
      m_w[l] = '0;
      m_a[l] = '0;
    end
  endtask

  task automatic clear_inputs();
    bus.md_req_i = 1'b0; bus.md_lock_i = 1'b0; bus.md_normal_i = 1'b0;
    bus.nu_req_i = 1'b0; bus.nu_lock_i = 1'b0;
    for (int l = 0; l < L; l++) begin
      bus.md_w_i[l] = '0; bus.md_a_i[l] = '0;
      bus.nu_w_i[l] = '0; bus.nu_a_i[l] = '0;
      bus.mul_p_i[l] = '0;
    end
  endtask

  task automatic rand_ops();
    for (int l = 0; l < L; l++) begin
      bus.md_w_i[l] = OW'($urandom); bus.md_a_i[l] = OW'($urandom);
      bus.nu_w_i[l] = OW'($urandom); bus.nu_a_i[l] = OW'($urandom);
    end
  endtask

  // Reset: check cleared outputs while held, and again after a clock edge under reset.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rvalid", {bus.md_rvalid_o, bus.nu_rvalid_o}, 2'b00);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_mul", {bus.mul_w_o[0], bus.mul_a_o[0], bus.mul_w_o[3], bus.mul_a_o[3], bus.mul_normal_o}, '0);
    @(posedge clk); #1;
    chk("rst_rvalid_hold", {bus.md_rvalid_o, bus.nu_rvalid_o, bus.busy_o}, 3'b000);
    rst = 1'b0;
  endtask

  // One clock cycle: predict, compare, then advance the model at the edge.
  task automatic step();
    bit g_md, g_nu, force_nu;
    logic signed [PW-1:0] prod [L];
    logic [255:0] o_md, e_md, o_nu, e_nu, o_w, e_w, o_a, e_a;
    g_md = 1'b0; g_nu = 1'b0;
    force_nu = GUARD && (m_wait == MAXW);
    if (m_lock == 1) g_md = bus.md_req_i;
    else if (m_lock == 2) g_nu = bus.nu_req_i;
    else if (bus.nu_req_i && force_nu) g_nu = 1'b1;
    else if (bus.md_req_i) g_md = 1'b1;
    else if (bus.nu_req_i) g_nu = 1'b1;
    for (int l = 0; l < L; l++) begin
      prod[l] = m_w[l] * m_a[l];
      bus.mul_p_i[l] = prod[l];
    end
    #1;
    o_md = '0; e_md = '0; o_nu = '0; e_nu = '0; o_w = '0; e_w = '0; o_a = '0; e_a = '0;
    for (int l = 0; l < L; l++) begin
      o_md[l*PW +: PW] = bus.md_p_o[l];
      e_md[l*PW +: PW] = (m_valid && m_owner == 1) ? prod[l] : '0;
      o_nu[l*32 +: 32] = bus.nu_p_o[l];
      e_nu[l*32 +: 32] = (m_valid && m_owner == 2) ? prod[l][31:0] : 32'h0;
      o_w[l*OW +: OW] = bus.mul_w_o[l];  e_w[l*OW +: OW] = m_w[l];
      o_a[l*OW +: OW] = bus.mul_a_o[l];  e_a[l*OW +: OW] = m_a[l];
    end
    chk("grant", {bus.md_gnt_o, bus.nu_gnt_o}, {g_md, g_nu});
    chk("rvalid", {bus.md_rvalid_o, bus.nu_rvalid_o}, {m_valid && m_owner == 1, m_valid && m_owner == 2});
    chk("md_p", o_md, e_md);
    chk("nu_p", o_nu, e_nu);
    chk("mul_w", o_w, e_w);
    chk("mul_a", o_a, e_a);
    chk("mul_normal", bus.mul_normal_o, m_normal);
    chk("busy", bus.busy_o, (m_lock != 0) || m_valid);
    seen_md_gnt = bus.md_gnt_o; seen_nu_gnt = bus.nu_gnt_o; seen_md_rvalid = bus.md_rvalid_o;
    seen_md_p0 = bus.md_p_o[0]; seen_nu_p0 = bus.nu_p_o[0]; seen_mul_w0 = bus.mul_w_o[0];
    @(posedge clk);
    if (g_md) begin
      m_valid = 1'b1; m_owner = 1; m_normal = bus.md_normal_i;
      for (int l = 0; l < L; l++) begin m_w[l] = bus.md_w_i[l]; m_a[l] = bus.md_a_i[l]; end
      m_lock = bus.md_lock_i ? 1 : 0;
    end else if (g_nu) begin
      m_valid = 1'b1; m_owner = 2; m_normal = 1'b0;
      for (int l = 0; l < L; l++) begin m_w[l] = bus.nu_w_i[l]; m_a[l] = bus.nu_a_i[l]; end
      m_lock = bus.nu_lock_i ? 2 : 0;
    end else begin
      m_valid = 1'b0;
      m_lock = 0;
    end
    if (g_nu) m_wait = 0;
    else if (bus.nu_req_i && m_wait < MAXW) m_wait++;
    #1;
  endtask

  initial begin
    int nu_cnt;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single-beat grant: 3 * -2 on lane 0.
    rand_ops();
    bus.md_req_i = 1'b1; bus.md_normal_i = 1'b1;
    bus.md_w_i[0] = 17'd3; bus.md_a_i[0] = 17'h1FFFE;
    step();
    chk("single_gnt", seen_md_gnt, 1'b1);
    bus.md_req_i = 1'b0;
    step();
    chk("single_rvalid", seen_md_rvalid, 1'b1);
    chk("single_mul_w0", seen_mul_w0, 17'd3);
    chk("single_md_p0", seen_md_p0, 34'h3_FFFF_FFFA);
    chk("single_nu_p0", seen_nu_p0, 32'h0);
    step();

    // Simultaneous requests in idle, then md drops.
    do_reset();
    rand_ops();
    bus.md_req_i = 1'b1; bus.nu_req_i = 1'b1;
    step();
    chk("simul_md_wins", {seen_md_gnt, seen_nu_gnt}, 2'b10);
    bus.md_req_i = 1'b0;
    step();
    chk("simul_nu_after", {seen_md_gnt, seen_nu_gnt}, 2'b01);
    bus.nu_req_i = 1'b0;
    step();

    // Neural lock burst with md requesting from beat 2.
    nu_cnt = 0;
    for (int b = 1; b <= 6; b++) begin
      rand_ops();
      bus.md_req_i  = (b >= 2);
      bus.nu_lock_i = (b <= 4);
      bus.nu_req_i  = (b <= 5);
      step();
      if (seen_nu_gnt) nu_cnt++;
      if (b == 6) chk("burst_md_after", {seen_md_gnt, seen_nu_gnt}, 2'b10);
    end
    chk("burst_nu_count", nu_cnt, 5);
    clear_inputs();
    step();

    // Starvation: both held, no locks.
    do_reset();
    nu_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      bus.md_req_i = 1'b1; bus.nu_req_i = 1'b1;
      step();
      if (seen_nu_gnt) nu_cnt++;
      if (i == 3) chk("starve_4th", seen_nu_gnt, GUARD);
    end
    chk("starve_count", nu_cnt, GUARD ? 3 : 0);
    clear_inputs();
    step();

    // Reset one cycle after a grant drops the in-flight product.
    rand_ops();
    bus.md_req_i = 1'b1;
    step();
    chk("inflight_gnt", seen_md_gnt, 1'b1);
    do_reset();
    step();
    chk("post_rst_rvalid", seen_md_rvalid, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      bus.md_req_i    = ($urandom_range(0, 3) != 0);
      bus.nu_req_i    = ($urandom_range(0, 2) != 0);
      bus.md_lock_i   = ($urandom_range(0, 2) == 0);
      bus.nu_lock_i   = ($urandom_range(0, 2) == 0);
      bus.md_normal_i = $urandom_range(0, 1) == 1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
